// File: rtl/ras_ctrl.sv
// Sequencer between the fetch/decode front end and the return address stack.
// Gates push/pop/branch/close strobes, tracks open checkpoints, registers return predictions.
module ras_ctrl #(
    parameter int WIDTH         = 32,
    parameter int MAX_BRANCHES  = 16,
    parameter int ADDR_BRANCHES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_call,
    input  logic                     req_ret,
    input  logic                     req_branch,
    input  logic [WIDTH-1:0]         req_addr,
    input  logic                     res_valid,
    input  logic                     res_mispredict,
    output logic                     res_ready,
    output logic                     ras_push,
    output logic                     ras_pop,
    output logic                     ras_branch,
    output logic                     ras_close_valid,
    output logic                     ras_close_invalid,
    output logic [WIDTH-1:0]         ras_din,
    input  logic [WIDTH-1:0]         ras_dout,
    input  logic                     ras_empty,
    output logic                     pred_valid,
    output logic [WIDTH-1:0]         pred_addr,
    output logic                     pred_empty,
    output logic [ADDR_BRANCHES:0]   outstanding,
    output logic [1:0]               dbg_state
);

    // Handshakes: a request is taken when req_valid && req_ready, a resolve
    // when res_valid && res_ready; both are decided combinationally in-cycle.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic [ADDR_BRANCHES:0] MAX_CNT = (ADDR_BRANCHES+1)'(MAX_BRANCHES);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BRANCHES:0] r_outstanding;
    logic                   r_pred_valid;
    logic                   r_pred_empty;

    logic w_res_ready;
    logic w_req_ready;
    logic w_res_acc;
    logic w_req_acc;
    logic w_mispredict_acc;

    always_comb begin
        w_res_ready      = !reset && (r_state == ST_RUN) && (r_outstanding != '0);
        w_res_acc        = res_valid && w_res_ready;
        w_mispredict_acc = w_res_acc && res_mispredict;
        // A flush blocks everything; a correct close only blocks opening a new checkpoint.
        w_req_ready      = !reset && (r_state != ST_RECOVER) && !w_mispredict_acc &&
                           !(req_branch && ((r_outstanding == MAX_CNT) || w_res_acc));
        w_req_acc        = req_valid && w_req_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_res_acc) w_state_nxt = res_mispredict ? ST_RECOVER : ST_SETTLE;
            end
            ST_SETTLE:  w_state_nxt = ST_RUN;
            ST_RECOVER: w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
        end else if (w_mispredict_acc) begin
            r_outstanding <= '0;
        end else if (w_req_acc && req_branch) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (w_res_acc) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    // The stack delivers the pre-push top one cycle later, so the prediction
    // qualifier is registered while the address itself passes through.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_valid <= 1'b0;
            r_pred_empty <= 1'b0;
        end else begin
            r_pred_valid <= w_req_acc && req_ret;
            r_pred_empty <= w_req_acc && req_ret && ras_empty && !req_call;
        end
    end

    always_comb begin
        req_ready         = w_req_ready;
        res_ready         = w_res_ready;
        ras_push          = w_req_acc && req_call;
        ras_branch        = w_req_acc && req_branch;
        ras_pop           = w_req_acc && req_ret && !(ras_empty && !req_call);
        ras_close_valid   = w_res_acc && !res_mispredict;
        ras_close_invalid = w_mispredict_acc;
        ras_din           = req_addr;
        pred_valid        = r_pred_valid;
        pred_empty        = r_pred_empty;
        pred_addr         = (r_pred_valid && !r_pred_empty) ? ras_dout : '0;
        outstanding       = r_outstanding;
        dbg_state         = r_state;
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: handshakes, strobes, prediction timing,
// checkpoint counting, settle/recover gaps and reset behaviour.
module tb_ras_ctrl;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_call, req_ret, req_branch;
    logic [WIDTH-1:0]  req_addr;
    logic              res_valid, res_mispredict, res_ready;
    logic              ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
    logic [WIDTH-1:0]  ras_din, ras_dout;
    logic              ras_empty;
    logic              pred_valid, pred_empty;
    logic [WIDTH-1:0]  pred_addr;
    logic [4:0]        outstanding;
    logic [1:0]        dbg_state;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] S_RUN = 2'd0, S_SETTLE = 2'd1, S_RECOVER = 2'd2;

    always #5 clk = ~clk;

    ras_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_call(req_call),
        .req_ret(req_ret), .req_branch(req_branch), .req_addr(req_addr),
        .res_valid(res_valid), .res_mispredict(res_mispredict), .res_ready(res_ready),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
        .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
        .ras_din(ras_din), .ras_dout(ras_dout), .ras_empty(ras_empty),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_empty(pred_empty),
        .outstanding(outstanding), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 0; req_call = 0; req_ret = 0; req_branch = 0; req_addr = '0;
        res_valid = 0; res_mispredict = 0;
    endtask

    task automatic req(input logic c, input logic r, input logic b, input logic [WIDTH-1:0] a);
        req_valid = 1; req_call = c; req_ret = r; req_branch = b; req_addr = a;
    endtask

    initial begin
        idle();
        ras_dout = '0;
        ras_empty = 1;
        reset = 1;
        @(posedge clk); #1;

        // While in reset nothing is accepted and no strobes fire.
        req(1, 0, 1, 32'h55); res_valid = 1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_push", ras_push, 0);
        chk("rst_branch", ras_branch, 0);
        tick();
        idle(); reset = 0;
        #1;
        chk("rst_state", dbg_state, S_RUN);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_empty", pred_empty, 0);
        chk("rst_pred_addr", pred_addr, 0);

        // Call 0x100 then return it.
        req(1, 0, 0, 32'h100);
        #1;
        chk("call_ready", req_ready, 1);
        chk("call_push", ras_push, 1);
        chk("call_din", ras_din, 32'h100);
        chk("call_pop", ras_pop, 0);
        tick();
        req(0, 1, 0, 32'h0); ras_empty = 0;
        #1;
        chk("ret_pop", ras_pop, 1);
        chk("ret_push", ras_push, 0);
        chk("ret_pred_idle", pred_valid, 0);
        tick();
        idle(); ras_dout = 32'h100; ras_empty = 1;
        #1;
        chk("ret_pred_valid", pred_valid, 1);
        chk("ret_pred_addr", pred_addr, 32'h100);
        chk("ret_pred_empty", pred_empty, 0);
        tick();
        chk("ret_pred_pulse", pred_valid, 0);

        // Return on empty stack: accepted, no pop, empty prediction.
        req(0, 1, 0, 32'h0); ras_empty = 1;
        #1;
        chk("eret_ready", req_ready, 1);
        chk("eret_pop", ras_pop, 0);
        tick();
        idle();
        #1;
        chk("eret_pred_valid", pred_valid, 1);
        chk("eret_pred_empty", pred_empty, 1);
        tick();

        // Coroutine on empty stack pops-then-pushes: push wins, pop not suppressed.
        req(1, 1, 0, 32'h200); ras_empty = 1;
        #1;
        chk("coro_pop", ras_pop, 1);
        chk("coro_push", ras_push, 1);
        tick();
        idle(); ras_dout = 32'h77;
        #1;
        chk("coro_pred_empty", pred_empty, 0);
        chk("coro_pred_addr", pred_addr, 32'h77);
        tick();
        ras_empty = 0;

        // Open 16 branches, each with a call.
        for (int i = 0; i < 16; i++) begin
            req(1, 0, 1, 32'h1000 + i);
            #1;
            if (i == 0 || i == 15) chk("open_branch", ras_branch, 1);
            tick();
        end
        idle();
        #1;
        chk("full_outstanding", outstanding, 16);
        req(1, 0, 1, 32'h2000);
        #1;
        chk("full_br_ready", req_ready, 0);
        chk("full_br_push", ras_push, 0);
        req(1, 0, 0, 32'h2000);
        #1;
        chk("full_call_ready", req_ready, 1);
        chk("full_call_push", ras_push, 1);
        tick();
        chk("full_hold", outstanding, 16);

        // Flush all 16 to get back to a clean count.
        idle(); res_valid = 1; res_mispredict = 1;
        #1;
        chk("flush16_inv", ras_close_invalid, 1);
        tick();
        idle();
        chk("flush16_cnt", outstanding, 0);
        tick();

        // Correct resolve with a plain call, outstanding 3 -> 2.
        for (int i = 0; i < 3; i++) begin
            req(0, 0, 1, 32'h0);
            tick();
        end
        idle();
        #1;
        chk("three_cnt", outstanding, 3);
        res_valid = 1; res_mispredict = 0; req(1, 0, 0, 32'h300);
        #1;
        chk("cv_close_valid", ras_close_valid, 1);
        chk("cv_close_invalid", ras_close_invalid, 0);
        chk("cv_push", ras_push, 1);
        chk("cv_req_ready", req_ready, 1);
        tick();
        #1;
        chk("cv_cnt", outstanding, 2);
        chk("settle_state", dbg_state, S_SETTLE);
        chk("settle_res_ready", res_ready, 0);
        chk("settle_close", ras_close_valid, 0);
        chk("settle_req_ready", req_ready, 1);
        req_valid = 0;
        tick();
        #1;
        chk("settle_done_res_ready", res_ready, 1);
        // Correct resolve blocks a branch-flagged request in the same cycle.
        req(1, 0, 1, 32'h400);
        #1;
        chk("cv_br_block", req_ready, 0);
        chk("cv_br_close", ras_close_valid, 1);
        tick();
        idle();
        chk("cv2_cnt", outstanding, 1);
        tick();

        // Build up to 5 outstanding, then mispredict with a request pending.
        for (int i = 0; i < 4; i++) begin
            req(0, 0, 1, 32'h0);
            tick();
        end
        idle();
        chk("five_cnt", outstanding, 5);
        res_valid = 1; res_mispredict = 1; req(1, 1, 1, 32'h500);
        #1;
        chk("mp_close_invalid", ras_close_invalid, 1);
        chk("mp_close_valid", ras_close_valid, 0);
        chk("mp_req_ready", req_ready, 0);
        chk("mp_push", ras_push, 0);
        chk("mp_pop", ras_pop, 0);
        chk("mp_branch", ras_branch, 0);
        tick();
        res_valid = 0;
        #1;
        chk("mp_cnt", outstanding, 0);
        chk("recover_state", dbg_state, S_RECOVER);
        chk("recover_req_ready", req_ready, 0);
        chk("recover_res_ready", res_ready, 0);
        tick();
        chk("post_recover_ready", req_ready, 1);
        chk("post_recover_state", dbg_state, S_RUN);
        // Resolve with nothing outstanding is ignored.
        idle(); res_valid = 1;
        #1;
        chk("res_zero_ready", res_ready, 0);
        chk("res_zero_close", ras_close_valid, 0);
        tick();
        idle();

        // Reset asserted during RECOVER, with a return's prediction in flight.
        req(0, 0, 1, 32'h0);
        tick();
        req(0, 1, 0, 32'h0);
        tick();
        idle(); res_valid = 1; res_mispredict = 1;
        #1;
        chk("pre_rst_pred", pred_valid, 1);
        tick();
        idle();
        chk("pre_rst_recover", dbg_state, S_RECOVER);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rr_state", dbg_state, S_RUN);
        chk("rr_pred_valid", pred_valid, 0);
        chk("rr_outstanding", outstanding, 0);
        chk("rr_req_ready", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Sequencer between the fetch/decode front end and the return address stack (`ras`). It accepts call/return/branch-checkpoint requests and in-order branch resolutions, and drives the stack's `push`/`pop`/`branch`/`close_valid`/`close_invalid` strobes without violating its sequencing rules. It counts outstanding speculative branches, enforces the settle and recovery gaps after a branch closes, and returns a registered return-address prediction one cycle after each pop.

## Interface

- `WIDTH`, 32, return address width; matches `ras` `WIDTH`.
- `MAX_BRANCHES`, 16, outstanding branch limit; matches `ras` `MAX_BRANCHES`.
- `ADDR_BRANCHES`, 4, log2(`MAX_BRANCHES`); the outstanding counter is `ADDR_BRANCHES+1` bits.

Ports:

- `clk`  in  1  single clock; everything is posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  front-end request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_call`  in  1  request pushes `req_addr`.
- `req_ret`  in  1  request pops; `req_call` and `req_ret` together mean pop-then-push (coroutine).
- `req_branch`  in  1  open a checkpoint after this request's push/pop.
- `req_addr`  in  WIDTH  return address to push.
- `res_valid`  in  1  resolution of the oldest outstanding branch.
- `res_mispredict`  in  1  1 = mispredicted (flush), 0 = correct.
- `res_ready`  out  1  resolution accepted when `res_valid && res_ready`.
- `ras_push`, `ras_pop`, `ras_branch`, `ras_close_valid`, `ras_close_invalid`  out  1 each  stack strobes.
- `ras_din`  out  WIDTH  equals `req_addr`.
- `ras_dout`  in  WIDTH  stack top read data; 1-cycle read latency.
- `ras_empty`  in  1  stack empty.
- `pred_valid`  out  1  prediction is valid this cycle.
- `pred_addr`  out  WIDTH  predicted return address.
- `pred_empty`  out  1  the return hit an empty stack; `pred_addr` is undefined.
- `outstanding`  out  ADDR_BRANCHES+1  number of open checkpoints.

## Operation

- FSM states:
  - RUN (reset state).
  - SETTLE: exactly 1 cycle, entered after an accepted correct resolve.
  - RECOVER: exactly 1 cycle, entered after an accepted mispredict.
- Transitions:
  - RUN goes to SETTLE on an accepted correct resolve.
  - RUN goes to RECOVER on an accepted mispredict.
  - SETTLE and RECOVER always return to RUN the next cycle.
- `res_ready` = state==RUN && `outstanding` != 0.
- `req_ready` = state!=RECOVER && !(res_valid && res_ready && res_mispredict) && !(req_branch && (outstanding==MAX_BRANCHES || (res_valid && res_ready))).
  - A mispredict blocks all requests that cycle.
  - A correct resolve blocks only requests with the branch flag; a call or return without `req_branch` proceeds alongside `ras_close_valid`.
- On an accepted request, in the same cycle:
  - `ras_push` = `req_call`.
  - `ras_branch` = `req_branch`.
  - `ras_pop` = `req_ret && !(ras_empty && !req_call)`.
  - A pop on an empty stack is suppressed. The request is still accepted and still produces a prediction, with `pred_empty`=1.
- On an accepted resolve:
  - `ras_close_invalid` = `res_mispredict`.
  - `ras_close_valid` = !`res_mispredict`.
  - `ras_close_valid` and `ras_close_invalid` are never both high.
- Outstanding counter:
  - +1 on an accepted `req_branch`.
  - -1 on an accepted correct resolve.
  - Cleared to 0 on an accepted mispredict; the flush discards all checkpoints.
  - An increment and a decrement in the same cycle cannot occur, by the `req_ready` rule.
  - The counter never exceeds `MAX_BRANCHES` and never goes below 0.
- `res_valid` while `outstanding`==0 is never accepted and has no effect.

## Timing

- Stack strobes are combinational from the handshakes: request or resolve accepted in cycle N drives the strobes in cycle N.
- Prediction: for an accepted request with `req_ret`, registered `pred_valid`=1 in N+1.
  - `pred_addr` = `ras_dout` in N+1, i.e. the top before any same-cycle push.
  - `pred_empty` registered from `ras_empty && !req_call` in N.
  - `pred_valid` is a single-cycle pulse per return.
- SETTLE: covers cycle N+1 after a close_valid in N. `res_ready`=0 there; requests are allowed.
- RECOVER: covers cycle N+1 after a close_invalid in N. `req_ready`=0 and `res_ready`=0 there.
- `outstanding` updates at the edge ending cycle N.
- Reset:
  - While `reset`=1: `req_ready`=0, `res_ready`=0, all `ras_*` strobes 0.
  - After the reset edge: state=RUN, `outstanding`=0, `pred_valid`=0, `pred_empty`=0, `pred_addr`=0.
  - Reset mid-SETTLE/RECOVER returns to RUN.
  - A pending `pred_valid` is dropped.

## Test plan

- Call with `req_addr`=0x100, then return: `ras_push` in cycle 0, `ras_pop` in cycle 1, `pred_valid`=1 with `pred_addr`=0x100 in cycle 2.
- Return on an empty stack: `ras_pop`=0, request accepted, next cycle `pred_valid`=1 and `pred_empty`=1.
- Open 16 branches (each with a call): `outstanding`=16, a 17th branch request sees `req_ready`=0; a plain call is still accepted.
- Correct resolve with a simultaneous call (no branch flag): `ras_close_valid` and `ras_push` in the same cycle, `outstanding` 3→2, `res_ready`=0 in the next cycle only.
- Mispredict with 5 outstanding and `req_valid`=1: `ras_close_invalid`=1, no `ras_*` request strobes, `outstanding`→0, `req_ready`=0 for that cycle and the next, accepted again 2 cycles later.
- Assert `reset` while in RECOVER with `pred_valid` pending: after the edge, state=RUN, `pred_valid`=0, `outstanding`=0.
